// File: rtl/kuznechik_apb_stream_master.sv
// Stream-to-APB feeder for the Kuznechik peripheral: writes DIN, pulses REQ, polls VALID, reads DOUT, writes ACK.
// Optional macro KUZ_STREAM_POLL_TIMEOUT_EN bounds VALID polling to POLL_LIMIT and re-initialises the core on expiry.
module kuznechik_apb_stream_master #(
    parameter int unsigned                APB_ADDR_WIDTH = 12,
    parameter int unsigned                APB_DATA_WIDTH = 32,
    parameter logic [APB_ADDR_WIDTH-1:0]  BASE_ADDR      = '0,
    parameter int unsigned                POLL_LIMIT     = 1024
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      s_valid_i,
    output logic                      s_ready_o,
    input  logic [127:0]              s_data_i,
    output logic                      m_valid_o,
    input  logic                      m_ready_i,
    output logic [127:0]              m_data_o,
    output logic [APB_ADDR_WIDTH-1:0] apb_paddr_o,
    output logic [APB_DATA_WIDTH-1:0] apb_pwdata_o,
    output logic                      apb_pwrite_o,
    output logic                      apb_psel_o,
    output logic                      apb_penable_o,
    input  logic [APB_DATA_WIDTH-1:0] apb_prdata_i,
    input  logic                      apb_pready_i,
    input  logic                      apb_pslverr_i,
    output logic                      busy_o,
    output logic                      err_o
);

    if (APB_DATA_WIDTH != 32 || POLL_LIMIT == 0 || POLL_LIMIT > 65536) begin : g_cfg_check
        $error("kuznechik_apb_stream_master: APB_DATA_WIDTH must be 32 and POLL_LIMIT 1..65536");
    end

    localparam logic [7:0] OFF_RST   = 8'h00;
    localparam logic [7:0] OFF_REQ   = 8'h04;
    localparam logic [7:0] OFF_ACK   = 8'h08;
    localparam logic [7:0] OFF_VALID = 8'h0C;
    localparam logic [7:0] OFF_DIN0  = 8'h14;
    localparam logic [7:0] OFF_DOUT0 = 8'h24;

    typedef enum logic [3:0] {
        ST_INIT, ST_IDLE, ST_WR_DIN, ST_WR_REQ, ST_POLL, ST_RD_DOUT, ST_WR_ACK, ST_OUT
`ifdef KUZ_STREAM_POLL_TIMEOUT_EN
        , ST_TO_RST0, ST_TO_RST1
`endif
    } state_t;

    state_t                      state_q, state_d;
    logic [1:0]                  cnt_q, cnt_d;
    logic [127:0]                blk_q, blk_d;
    logic [127:0]                res_q;
    logic                        s_ready_q, m_valid_q, busy_q, err_q;
    logic                        psel_q, penable_q, pwrite_q;
    logic [APB_ADDR_WIDTH-1:0]   paddr_q;
    logic [31:0]                 pwdata_q;
`ifdef KUZ_STREAM_POLL_TIMEOUT_EN
    logic [15:0]                 poll_cnt_q;
`endif

    logic                        done;
    logic                        xfer_en, xfer_wr;
    logic [7:0]                  xfer_off;
    logic [31:0]                 xfer_wdata;

    assign done = psel_q & penable_q & apb_pready_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        case (state_q)
            ST_INIT:    if (done) state_d = ST_IDLE;
            ST_IDLE:    if (s_valid_i && s_ready_q) begin
                            blk_d   = s_data_i;
                            state_d = ST_WR_DIN;
                        end
            ST_WR_DIN:  if (done) begin
                            cnt_d = cnt_q + 2'd1;
                            if (cnt_q == 2'd3) state_d = ST_WR_REQ;
                        end
            ST_WR_REQ:  if (done) state_d = ST_POLL;
            ST_POLL:    if (done) begin
                            if (apb_prdata_i[0]) state_d = ST_RD_DOUT;
`ifdef KUZ_STREAM_POLL_TIMEOUT_EN
                            else if (poll_cnt_q == 16'(POLL_LIMIT - 1)) state_d = ST_TO_RST0;
`endif
                        end
            ST_RD_DOUT: if (done) begin
                            cnt_d = cnt_q + 2'd1;
                            if (cnt_q == 2'd3) state_d = ST_WR_ACK;
                        end
            ST_WR_ACK:  if (done) state_d = ST_OUT;
            ST_OUT:     if (m_ready_i) state_d = ST_IDLE;
`ifdef KUZ_STREAM_POLL_TIMEOUT_EN
            ST_TO_RST0: if (done) state_d = ST_TO_RST1;
            ST_TO_RST1: if (done) state_d = ST_OUT;
`endif
            default:    state_d = ST_INIT;
        endcase
    end

    // Describes the transfer owned by the next state so a SETUP can follow a completion with psel held high.
    always_comb begin
        xfer_en    = 1'b1;
        xfer_wr    = 1'b1;
        xfer_off   = OFF_RST;
        xfer_wdata = 32'd1;
        case (state_d)
            ST_INIT:    ;
            ST_WR_DIN:  begin
                            xfer_off   = OFF_DIN0 + {4'b0, cnt_d, 2'b00};
                            xfer_wdata = blk_d[{cnt_d, 5'd0} +: 32];
                        end
            ST_WR_REQ:  xfer_off = OFF_REQ;
            ST_POLL:    begin
                            xfer_wr    = 1'b0;
                            xfer_off   = OFF_VALID;
                            xfer_wdata = '0;
                        end
            ST_RD_DOUT: begin
                            xfer_wr    = 1'b0;
                            xfer_off   = OFF_DOUT0 + {4'b0, cnt_d, 2'b00};
                            xfer_wdata = '0;
                        end
            ST_WR_ACK:  xfer_off = OFF_ACK;
`ifdef KUZ_STREAM_POLL_TIMEOUT_EN
            ST_TO_RST0: xfer_wdata = '0;
            ST_TO_RST1: ;
`endif
            default:    xfer_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            blk_q      <= '0;
            res_q      <= '0;
            s_ready_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            busy_q     <= 1'b1;
            err_q      <= 1'b0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
`ifdef KUZ_STREAM_POLL_TIMEOUT_EN
            poll_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            blk_q     <= blk_d;
            s_ready_q <= (state_d == ST_IDLE);
            m_valid_q <= (state_d == ST_OUT);
            busy_q    <= (state_d != ST_IDLE);
            if (done && apb_pslverr_i) err_q <= 1'b1;
            if (done && state_q == ST_RD_DOUT) res_q[{cnt_q, 5'd0} +: 32] <= apb_prdata_i;
            if (!psel_q || done) begin
                psel_q    <= xfer_en;
                penable_q <= 1'b0;
                if (xfer_en) begin
                    paddr_q  <= BASE_ADDR + APB_ADDR_WIDTH'(xfer_off);
                    pwdata_q <= xfer_wdata;
                    pwrite_q <= xfer_wr;
                end
            end else if (!penable_q) begin
                penable_q <= 1'b1;
            end
`ifdef KUZ_STREAM_POLL_TIMEOUT_EN
            if (state_d == ST_POLL && state_q != ST_POLL) poll_cnt_q <= '0;
            else if (done && state_q == ST_POLL) poll_cnt_q <= poll_cnt_q + 16'd1;
            if (state_q == ST_POLL && state_d == ST_TO_RST0) begin
                err_q <= 1'b1;
                res_q <= '0;
            end
`endif
        end
    end

    assign s_ready_o     = s_ready_q;
    assign m_valid_o     = m_valid_q;
    assign m_data_o      = res_q;
    assign busy_o        = busy_q;
    assign err_o         = err_q;
    assign apb_psel_o    = psel_q;
    assign apb_penable_o = penable_q;
    assign apb_pwrite_o  = pwrite_q;
    assign apb_paddr_o   = paddr_q;
    assign apb_pwdata_o  = pwdata_q;

endmodule

// File: tb/tb_kuznechik_apb_stream_master.sv
// Bench for kuznechik_apb_stream_master: APB peripheral model with a stand-in cipher, transfer log and stream scoreboard.
`timescale 1ns/1ps
module tb_kuznechik_apb_stream_master;

    localparam logic [127:0] PT = 128'h1122334455667700ffeeddccbbaa9988;
    localparam logic [127:0] CT = 128'h7f679d90bebc24305a468d42b9d4edcd;
    localparam logic [11:0] A_RST = 12'h000, A_REQ = 12'h004, A_ACK = 12'h008, A_VALID = 12'h00C;
    localparam logic [11:0] A_DIN0 = 12'h014, A_DOUT0 = 12'h024;

    logic         clk = 1'b0, rstn = 1'b0;
    logic         s_valid = 1'b0, s_ready, m_valid, m_ready = 1'b0;
    logic [127:0] s_data = '0, m_data;
    logic [11:0]  paddr;
    logic [31:0]  pwdata, prdata;
    logic         pwrite, psel, penable, pready, pslverr, busy, err;

    int nchk = 0, nfail = 0;

    always #5 clk = ~clk;

    kuznechik_apb_stream_master #(
        .APB_ADDR_WIDTH(12), .APB_DATA_WIDTH(32), .BASE_ADDR(12'h000), .POLL_LIMIT(8)
    ) dut (
        .clk_i(clk), .rstn_i(rstn),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
        .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data),
        .apb_paddr_o(paddr), .apb_pwdata_o(pwdata), .apb_pwrite_o(pwrite),
        .apb_psel_o(psel), .apb_penable_o(penable), .apb_prdata_i(prdata),
        .apb_pready_i(pready), .apb_pslverr_i(pslverr),
        .busy_o(busy), .err_o(err)
    );

    // Stand-in cipher: the known test vector, otherwise a word rotation with a mask.
    function automatic logic [127:0] cipher_f(input logic [127:0] x);
        if (x == PT) return CT;
        return {x[95:0], x[127:96]} ^ 128'h0123456789abcdeffedcba9876543210;
    endfunction

    // ---------------- APB peripheral model ----------------
    logic [31:0]  din [4];
    logic [127:0] dout;
    logic         req_pend;
    int           polls_left;
    logic         never_valid = 1'b0, err_en = 1'b0;
    logic [11:0]  err_addr = 12'h01C;
    logic         compl;

    assign compl   = psel & penable & pready;
    assign pslverr = pready & err_en & (paddr == err_addr);

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pready     <= 1'b0;
            req_pend   <= 1'b0;
            polls_left <= 0;
        end else begin
            pready <= psel && penable && !pready;
            if (compl && pwrite) begin
                case (paddr)
                    12'h014: din[0] <= pwdata;
                    12'h018: din[1] <= pwdata;
                    12'h01C: din[2] <= pwdata;
                    12'h020: din[3] <= pwdata;
                    A_REQ:   begin
                                 dout       <= cipher_f({din[3], din[2], din[1], din[0]});
                                 req_pend   <= 1'b1;
                                 polls_left <= 2;
                             end
                    A_ACK:   req_pend <= 1'b0;
                    A_RST:   if (pwdata[0]) begin
                                 req_pend   <= 1'b0;
                                 polls_left <= 0;
                             end
                    default: ;
                endcase
            end else if (compl && paddr == A_VALID && polls_left > 0) begin
                polls_left <= polls_left - 1;
            end
        end
    end

    always_comb begin
        prdata = '0;
        case (paddr)
            A_VALID: prdata = {31'd0, req_pend && polls_left == 0 && !never_valid};
            12'h024: prdata = dout[31:0];
            12'h028: prdata = dout[63:32];
            12'h02C: prdata = dout[95:64];
            12'h030: prdata = dout[127:96];
            default: prdata = '0;
        endcase
    end

    // ---------------- transfer log ----------------
    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] data;
        int          len;
        logic        stable;
    } xfer_t;
    xfer_t       log_q[$];
    int          cyc_in = 0;
    logic [11:0] a0 = '0;
    logic [31:0] d0 = '0;
    logic        w0 = 1'b0, stab = 1'b0;

    always @(posedge clk) begin
        if (psel && !penable) begin
            cyc_in <= 1;
            a0     <= paddr;
            d0     <= pwdata;
            w0     <= pwrite;
            stab   <= 1'b1;
        end else if (psel && penable) begin
            cyc_in <= cyc_in + 1;
            if (paddr !== a0 || pwdata !== d0 || pwrite !== w0) stab <= 1'b0;
            if (pready)
                log_q.push_back('{pwrite, paddr, pwrite ? pwdata : prdata, cyc_in + 1,
                                  stab && paddr === a0 && pwdata === d0 && pwrite === w0});
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_x(input string tag, input logic wr, input logic [11:0] a, input logic [31:0] d);
        xfer_t x;
        chk({tag, "_present"}, 160'(log_q.size() > 0), 160'd1);
        if (log_q.size() == 0) return;
        x = log_q.pop_front();
        chk(tag, 160'({x.wr, x.addr, x.data}), 160'({wr, a, d}));
        chk({tag, "_len"}, 160'(x.len), 160'(3));
        chk({tag, "_stable"}, 160'(x.stable), 160'd1);
    endtask

    task automatic check_log(input logic [127:0] d, input logic timeout);
        logic [127:0] r;
        r = cipher_f(d);
        for (int k = 0; k < 4; k++) expect_x("din", 1'b1, A_DIN0 + 12'(4 * k), d[32*k +: 32]);
        expect_x("req", 1'b1, A_REQ, 32'd1);
        if (timeout) begin
            for (int k = 0; k < 8; k++) expect_x("poll_to", 1'b0, A_VALID, 32'd0);
            expect_x("rst0", 1'b1, A_RST, 32'd0);
            expect_x("rst1", 1'b1, A_RST, 32'd1);
        end else begin
            expect_x("poll0", 1'b0, A_VALID, 32'd0);
            expect_x("poll1", 1'b0, A_VALID, 32'd0);
            expect_x("poll2", 1'b0, A_VALID, 32'd1);
            for (int k = 0; k < 4; k++) expect_x("dout", 1'b0, A_DOUT0 + 12'(4 * k), r[32*k +: 32]);
            expect_x("ack", 1'b1, A_ACK, 32'd1);
        end
        chk("log_extra", 160'(log_q.size()), 160'd0);
    endtask

    task automatic do_reset();
        int n;
        rstn = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        #1;
        chk("reset_stream", 160'({s_ready, m_valid, m_data, busy, err}), 160'({1'b0, 1'b0, 128'd0, 1'b1, 1'b0}));
        chk("reset_apb", 160'({psel, penable, pwrite, paddr, pwdata}), 160'({1'b0, 1'b0, 1'b0, 12'd0, 32'd0}));
        @(negedge clk); @(negedge clk);
        log_q.delete();
        rstn = 1'b1;
        n = 0;
        while (!s_ready && n < 100) begin @(negedge clk); n++; end
        expect_x("init_rst", 1'b1, A_RST, 32'd1);
        chk("init_idle", 160'({s_ready, busy}), 160'({1'b1, 1'b0}));
    endtask

    task automatic offer_block(input logic [127:0] d);
        int n;
        s_data = d; s_valid = 1'b1; n = 0;
        while (!s_ready && n < 1000) begin @(negedge clk); n++; end
        chk("s_ready_wait", 160'(s_ready), 160'd1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_out(input logic [127:0] d, input logic [127:0] exp, input logic timeout);
        int n;
        n = 0;
        while (!m_valid && n < 2000) begin @(negedge clk); n++; end
        chk("m_valid_wait", 160'(m_valid), 160'd1);
        chk("m_data", 160'(m_data), 160'(exp));
        check_log(d, timeout);
    endtask

    task automatic release_out(input int hold);
        logic [127:0] snap;
        snap = m_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("out_hold", 160'({m_valid, s_ready, psel, m_data}), 160'({1'b1, 1'b0, 1'b0, snap}));
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        chk("out_done", 160'({m_valid, s_ready, busy}), 160'({1'b0, 1'b1, 1'b0}));
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d, d2;
        int n;
        @(negedge clk);
        // Reset values, then the initial RST write and IDLE.
        do_reset();

        // Known vector through the full register sequence.
        offer_block(PT);
        wait_out(PT, CT, 1'b0);
        release_out(0);

        // Random blocks with random consumer back-pressure.
        for (int i = 0; i < 4; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            offer_block(d);
            wait_out(d, cipher_f(d), 1'b0);
            release_out(int'($urandom_range(3, 0)));
        end

        // Long back-pressure with a new block already waiting upstream.
        d  = {$urandom, $urandom, $urandom, $urandom};
        d2 = {$urandom, $urandom, $urandom, $urandom};
        offer_block(d);
        wait_out(d, cipher_f(d), 1'b0);
        s_data = d2; s_valid = 1'b1;
        release_out(20);
        @(negedge clk);
        s_valid = 1'b0;
        chk("accept_after_out", 160'({s_ready, busy}), 160'({1'b0, 1'b1}));
        wait_out(d2, cipher_f(d2), 1'b0);
        release_out(0);

        // Slave error on the DIN2 write.
        err_en = 1'b1;
        d = {$urandom, $urandom, $urandom, $urandom};
        offer_block(d);
        n = 0;
        while (!(psel && penable && pready && paddr == 12'h01C) && n < 200) begin @(negedge clk); n++; end
        chk("err_before", 160'({psel, penable, pready, err}), 160'({1'b1, 1'b1, 1'b1, 1'b0}));
        @(negedge clk);
        chk("err_set", 160'(err), 160'd1);
        err_en = 1'b0;
        wait_out(d, cipher_f(d), 1'b0);
        release_out(1);
        d = {$urandom, $urandom, $urandom, $urandom};
        offer_block(d);
        wait_out(d, cipher_f(d), 1'b0);
        chk("err_sticky", 160'(err), 160'd1);
        release_out(0);

        // Reset in the middle of the VALID poll access phase.
        d = {$urandom, $urandom, $urandom, $urandom};
        offer_block(d);
        n = 0;
        while (!(psel && penable && paddr == A_VALID) && n < 200) begin @(negedge clk); n++; end
        chk("poll_reached", 160'({psel, penable}), 160'({1'b1, 1'b1}));
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no_stale_out", 160'({m_valid, s_ready}), 160'({1'b0, 1'b1}));
        end
        d = {$urandom, $urandom, $urandom, $urandom};
        offer_block(d);
        wait_out(d, cipher_f(d), 1'b0);
        release_out(0);

`ifdef KUZ_STREAM_POLL_TIMEOUT_EN
        // VALID never asserted: bounded polling, core re-init, zero result.
        never_valid = 1'b1;
        d = {$urandom, $urandom, $urandom, $urandom};
        offer_block(d);
        wait_out(d, 128'd0, 1'b1);
        chk("timeout_err", 160'(err), 160'd1);
        release_out(0);
        never_valid = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
